cmd_line_buffer: RTL and testbench
==================================

CMD_LINE_BUFFER -- requirements
Module: cmd_line_buffer

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning the character width in bits; it covers the ASCII range.
REQ-002 The block SHALL expose parameter DEPTH, default 32, meaning the maximum number of characters stored per line.
REQ-003 The block SHALL expose parameter ECHO_EN, default 1; 1 echoes keystrokes to the printer and 0 suppresses all echo.
REQ-004 The block SHALL have one clock, clk, input, width 1; it is the single rising-edge clock.
REQ-005 The block SHALL have rst_n, input, width 1, an asynchronous active-low reset.
REQ-006 The block SHALL have key_data, input, width DATA_W, the keystroke code from the keyboard front end.
REQ-007 The block SHALL have key_valid, input, width 1, which qualifies key_data.
REQ-008 The block SHALL have key_ready, output, width 1; a key transfers when key_valid and key_ready are both high.
REQ-009 The block SHALL have echo_data, output, width DATA_W, the character sent to the printer.
REQ-010 The block SHALL have echo_valid, output, width 1, and echo_ready, input, width 1; an echo transfers when both are high.
REQ-011 The block SHALL have line_rd_idx, input, width $clog2(DEPTH), and line_rd_data, output, width DATA_W; this is a combinational read port into the committed line.
REQ-012 The block SHALL have line_len, output, width $clog2(DEPTH+1), the length of the committed line.
REQ-013 The block SHALL have line_done, output, width 1, a level that stays high while a committed line awaits the state machine.
REQ-014 The block SHALL have line_ack, input, width 1; the state machine pulses it to release the line.
REQ-015 The block SHALL have overflow, output, width 1, a sticky flag indicating that a character was dropped on the current line.

Function
REQ-016 The block SHALL implement three states, EDIT, ECHO and DONE; EDIT→ECHO on any accepted key that produces echo, ECHO→EDIT when the echo queue drains, ECHO→DONE when the drained sequence was the CR/LF of a commit, and DONE→EDIT on line_ack.
REQ-017 key_ready SHALL equal (state==EDIT).
REQ-018 A printable key (0x20..0x7E) with count<DEPTH SHALL be written at buf[count], increment count, and queue an echo of the same character.
REQ-019 A printable key with count==DEPTH SHALL be dropped, set overflow, and queue echo 0x07 (BEL).
REQ-020 A backspace key (0x08 or 0x7F) with count>0 SHALL decrement count and queue the echo 0x08, 0x20, 0x08 in that order.
REQ-021 A backspace key with count==0 SHALL be consumed without any echo, and the block SHALL stay in EDIT.
REQ-022 An enter key (0x0D) SHALL latch line_len=count and queue the echo 0x0D, 0x0A; line_done SHALL rise on the cycle after the 0x0A transfer.
REQ-023 All other codes SHALL be consumed and ignored, with no echo and no state change.
REQ-024 echo_valid SHALL assert on the cycle after key acceptance (latency 1).
REQ-025 echo_data SHALL stay stable while echo_valid is high and echo_ready is low.
REQ-026 With ECHO_EN=0, echo_valid SHALL stay 0, the ECHO state SHALL be skipped, and line_done SHALL rise on the cycle after enter is accepted.
REQ-027 In DONE, line_rd_data SHALL equal buf[line_rd_idx] for line_rd_idx<line_len, and SHALL be 0 otherwise.
REQ-028 On line_ack in DONE, the block SHALL clear count, overflow and line_done on the next edge and return to EDIT.
REQ-029 line_ack outside DONE SHALL be ignored.
REQ-030 A commit of an empty line SHALL be legal and SHALL give line_len=0.

Reset
REQ-031 While rst_n is low, state SHALL be EDIT, count SHALL be 0, and line_len SHALL be 0.
REQ-032 While rst_n is low, line_done, overflow, echo_valid and echo_data SHALL all be 0.
REQ-033 Reset mid-echo or in DONE SHALL abandon the pending echo and line immediately; buffer contents need not be cleared.
REQ-034 key_ready SHALL be 1 on the first clock after rst_n deasserts.

Structure
REQ-035 A shared package cmd_pkg SHALL hold the ASCII constants (BS, DEL, CR, LF, SP, BEL) and the state enum.
REQ-036 The design SHALL use one sub-module, echo_seq: a 3-entry echo sequencer with a load port, a valid/ready output, and a done pulse.

Verification
REQ-037 Scenario: after reset, send "ab", then CR, with echo_ready=1 → echo a, b, 0x0D, 0x0A; then line_done=1, line_len=2, idx0=0x61, idx1=0x62.
REQ-038 Scenario: send "abc", then 0x08, then CR → echo includes 0x08,0x20,0x08, then line_len=2 with "ab" stored.
REQ-039 Scenario: backspace at count=0 → no echo_valid, key_ready stays 1, count stays 0.
REQ-040 Scenario: send DEPTH+1 characters "x" → the last echo is 0x07, overflow=1, and line_len=DEPTH after CR.
REQ-041 Scenario: hold echo_ready=0 for 5 cycles → echo_data stable and key_ready=0 throughout; the transfer completes when echo_ready=1.
REQ-042 Scenario: assert rst_n low during the 0x20 of a backspace echo → all outputs return to reset values, and a new key is accepted next cycle.

Source files
------------

// File: rtl/cmd_line_buffer_pkg.sv
// cmd_pkg: shared constants and types for the command-line buffer.
//   ASC_*   : ASCII codes the editor reacts to or emits
//   state_t : editor state (EDIT accepts keys, ECHO drains the printer
//             queue, DONE holds a committed line until acknowledged)
//   SEQ_N   : depth of the echo sequencer (longest echo is BS,SP,BS)
package cmd_pkg;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_DEL   = 8'h7F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_BEL   = 8'h07;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam int SEQ_N = 3;

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_ECHO = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cmd_line_buffer_echo_seq.sv
// echo_seq: up to three queued echo characters presented on a
// valid/ready port, entry 0 first.
//   clk, rst_n : clock, async active-low reset
//   i_load     : capture i_seq/i_cnt (only issued while the queue is empty)
//   i_cnt      : number of entries to send (1..3)
//   i_seq      : characters, entry 0 goes out first
//   o_valid/o_data/i_ready : printer handshake
//   o_done     : single-cycle pulse when the last entry transfers
module echo_seq
  import cmd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_load,
  input  logic [1:0]                   i_cnt,
  input  logic [SEQ_N-1:0][DATA_W-1:0] i_seq,
  output logic                         o_valid,
  output logic [DATA_W-1:0]            o_data,
  input  logic                         i_ready,
  output logic                         o_done
);
  logic [SEQ_N-1:0][DATA_W-1:0] r_q;
  logic [1:0]                   r_cnt;
  logic                         w_xfer;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_q[0];
  assign w_xfer  = o_valid & i_ready;
  assign o_done  = w_xfer & (r_cnt == 2'd1);

  // Shift toward entry 0 on each transfer; zeros fill in behind so the
  // data output idles at 0 once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_q   <= i_seq;
      r_cnt <= i_cnt;
    end else if (w_xfer) begin
      r_q   <= {{DATA_W{1'b0}}, r_q[SEQ_N-1:1]};
      r_cnt <= r_cnt - 2'd1;
    end
  end
endmodule

// File: rtl/cmd_line_buffer.sv
// cmd_line_buffer: line editor between a keyboard and a printer.
// Printable keys are stored and echoed, backspace erases on screen with
// BS,SP,BS, CR commits the line (echo CR,LF) and holds it for a reader.
//   clk, rst_n             : clock, async active-low reset
//   key_data/valid/ready   : keystroke input handshake
//   echo_data/valid/ready  : printer output handshake
//   line_rd_idx/rd_data    : combinational read of the committed line
//   line_len, line_done    : committed length, line-held level
//   line_ack               : releases a held line
//   overflow               : sticky, a key was dropped on this line
module cmd_line_buffer
  import cmd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int ECHO_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          key_data,
  input  logic                       key_valid,
  output logic                       key_ready,
  output logic [DATA_W-1:0]          echo_data,
  output logic                       echo_valid,
  input  logic                       echo_ready,
  input  logic [$clog2(DEPTH)-1:0]   line_rd_idx,
  output logic [DATA_W-1:0]          line_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] line_len,
  output logic                       line_done,
  input  logic                       line_ack,
  output logic                       overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  state_t                       r_state, w_state_nxt;
  logic [LW-1:0]                r_count, w_count_nxt;
  logic [LW-1:0]                r_len, w_len_nxt;
  logic                         r_ovf, w_ovf_nxt;
  logic                         r_commit, w_commit_nxt;
  logic [DEPTH-1:0][DATA_W-1:0] r_buf;

  logic                         w_load, w_wr;
  logic [1:0]                   w_ld_cnt;
  logic [SEQ_N-1:0][DATA_W-1:0] w_ld_seq;
  logic                         w_seq_done;
  logic                         w_print, w_bs, w_cr;
  logic                         w_rd_ok;

  assign w_print = (key_data >= DATA_W'(ASC_SP)) && (key_data <= DATA_W'(ASC_TILDE));
  assign w_bs    = (key_data == DATA_W'(ASC_BS)) || (key_data == DATA_W'(ASC_DEL));
  assign w_cr    = (key_data == DATA_W'(ASC_CR));

  assign key_ready = (r_state == ST_EDIT);
  assign line_done = (r_state == ST_DONE);
  assign line_len  = r_len;
  assign overflow  = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EDIT;
      r_count  <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_len    <= w_len_nxt;
      r_ovf    <= w_ovf_nxt;
      r_commit <= w_commit_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_len_nxt    = r_len;
    w_ovf_nxt    = r_ovf;
    w_commit_nxt = r_commit;
    w_load       = 1'b0;
    w_wr         = 1'b0;
    w_ld_cnt     = 2'd0;
    w_ld_seq     = '0;
    unique case (r_state)
      ST_EDIT: begin
        if (key_valid) begin
          if (w_print) begin
            w_load   = 1'b1;
            w_ld_cnt = 2'd1;
            if (r_count < LW'(DEPTH)) begin
              w_wr        = 1'b1;
              w_count_nxt = r_count + LW'(1);
              w_ld_seq[0] = key_data;
            end else begin
              w_ovf_nxt   = 1'b1;
              w_ld_seq[0] = DATA_W'(ASC_BEL);
            end
          end else if (w_bs && (r_count != '0)) begin
            w_count_nxt = r_count - LW'(1);
            w_load      = 1'b1;
            w_ld_cnt    = 2'd3;
            w_ld_seq[0] = DATA_W'(ASC_BS);
            w_ld_seq[1] = DATA_W'(ASC_SP);
            w_ld_seq[2] = DATA_W'(ASC_BS);
          end else if (w_cr) begin
            w_len_nxt    = r_count;
            w_commit_nxt = 1'b1;
            w_load       = 1'b1;
            w_ld_cnt     = 2'd2;
            w_ld_seq[0]  = DATA_W'(ASC_CR);
            w_ld_seq[1]  = DATA_W'(ASC_LF);
          end
          // Without echo there is nothing to drain, so a commit goes
          // straight to DONE and every other key stays in EDIT.
          if (w_load)
            w_state_nxt = (ECHO_EN != 0) ? ST_ECHO : (w_cr ? ST_DONE : ST_EDIT);
        end
      end
      ST_ECHO: begin
        if (w_seq_done) begin
          w_state_nxt  = r_commit ? ST_DONE : ST_EDIT;
          w_commit_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        if (line_ack) begin
          w_state_nxt  = ST_EDIT;
          w_count_nxt  = '0;
          w_ovf_nxt    = 1'b0;
          w_commit_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_EDIT;
    endcase
  end

  // Line storage needs no reset: only entries below line_len are visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_count[IW-1:0]] <= key_data;
  end

  assign w_rd_ok      = (r_state == ST_DONE) && (LW'(line_rd_idx) < r_len);
  assign line_rd_data = w_rd_ok ? r_buf[line_rd_idx] : '0;

  echo_seq #(.DATA_W(DATA_W)) u_echo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load && (ECHO_EN != 0)),
    .i_cnt   (w_ld_cnt),
    .i_seq   (w_ld_seq),
    .o_valid (echo_valid),
    .o_data  (echo_data),
    .i_ready (echo_ready),
    .o_done  (w_seq_done)
  );
endmodule

// File: tb/tb_cmd_line_buffer.sv
module tb_cmd_line_buffer;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic       echo_ready;
  logic [2:0] line_rd_idx = 3'd0;
  logic [7:0] line_rd_data;
  logic [3:0] line_len;
  logic       line_done;
  logic       line_ack = 1'b0;
  logic       overflow;

  logic rdy_rand = 1'b0, rdy_fix = 1'b1, rdy_rnd = 1'b1;
  assign echo_ready = rdy_rand ? rdy_rnd : rdy_fix;

  always #5 clk = ~clk;

  cmd_line_buffer #(.DATA_W(8), .DEPTH(DEPTH), .ECHO_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready),
    .line_rd_idx(line_rd_idx), .line_rd_data(line_rd_data),
    .line_len(line_len), .line_done(line_done), .line_ack(line_ack),
    .overflow(overflow)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_line[$];   // characters typed on the current line
  logic [7:0] m_com[$];    // line as committed by CR
  logic [7:0] m_echo[$];   // characters still owed to the printer
  logic [7:0] elog[$];     // characters the printer actually received
  bit         m_done, m_ovf, m_commit;
  int         m_len;

  task automatic m_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      if (m_line.size() < DEPTH) begin
        m_line.push_back(k);
        m_echo.push_back(k);
      end else begin
        m_ovf = 1;
        m_echo.push_back(8'h07);
      end
    end else if (k == 8'h08 || k == 8'h7F) begin
      if (m_line.size() != 0) begin
        void'(m_line.pop_back());
        m_echo.push_back(8'h08); m_echo.push_back(8'h20); m_echo.push_back(8'h08);
      end
    end else if (k == 8'h0D) begin
      m_com = m_line;
      m_len = m_line.size();
      m_echo.push_back(8'h0D); m_echo.push_back(8'h0A);
      m_commit = 1;
    end
  endtask

  // Compare process: check outputs against the model, then advance the
  // model by what the upcoming edge will transfer.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_key_ready", key_ready, 1);
      chk("rst_echo_valid", echo_valid, 0);
      chk("rst_echo_data", echo_data, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_line_len", line_len, 0);
      m_line.delete(); m_com.delete(); m_echo.delete();
      m_done = 0; m_ovf = 0; m_commit = 0; m_len = 0;
    end else begin
      bit m_rdy;
      m_rdy = !m_done && (m_echo.size() == 0);
      chk("key_ready", key_ready, m_rdy);
      chk("echo_valid", echo_valid, m_echo.size() != 0);
      if (m_echo.size() != 0) chk("echo_data", echo_data, m_echo[0]);
      chk("line_done", line_done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("line_len", line_len, m_len);
      if (m_done)
        chk("line_rd_data", line_rd_data, (line_rd_idx < m_len) ? m_com[line_rd_idx] : 8'h00);
      if (m_echo.size() != 0 && echo_ready) begin
        elog.push_back(echo_data);
        void'(m_echo.pop_front());
        if (m_echo.size() == 0 && m_commit) begin m_done = 1; m_commit = 0; end
      end else if (key_valid && m_rdy) begin
        m_key(key_data);
      end else if (line_ack && m_done) begin
        m_done = 0; m_ovf = 0; m_line.delete();
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_key(input logic [7:0] k);
    int n = 0;
    while (!key_ready && n < 200) begin cyc(1); n++; end
    if (!key_ready) begin chk("send_timeout", key_ready, 1); return; end
    key_data = k; key_valid = 1'b1;
    cyc(1);
    key_valid = 1'b0; key_data = 8'($urandom);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_key(s[i]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!line_done && n < 200) begin cyc(1); n++; end
    chk("done_timeout", line_done, 1);
  endtask

  task automatic ack();
    line_ack = 1'b1; cyc(1); line_ack = 1'b0;
  endtask

  task automatic peek(input logic [2:0] idx, input logic [7:0] exp, input string nm);
    line_rd_idx = idx;
    @(negedge clk); chk(nm, line_rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] k;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk); chk("key_ready_after_rst", key_ready, 1);
    @(posedge clk); #1;

    // "ab" + CR with the printer always ready
    elog.delete();
    send_str("ab"); send_key(8'h0D);
    wait_done();
    chk("s1_echo_n", elog.size(), 4);
    chk("s1_echo0", elog[0], 8'h61);
    chk("s1_echo1", elog[1], 8'h62);
    chk("s1_echo2", elog[2], 8'h0D);
    chk("s1_echo3", elog[3], 8'h0A);
    chk("s1_len", line_len, 2);
    peek(3'd0, 8'h61, "s1_idx0");
    peek(3'd1, 8'h62, "s1_idx1");
    peek(3'd5, 8'h00, "s1_idx_beyond");
    ack();
    @(negedge clk); chk("s1_done_cleared", line_done, 0);
    @(posedge clk); #1;

    // backspace on an empty line, then an empty commit
    elog.delete();
    send_key(8'h08);
    repeat (2) begin
      @(negedge clk);
      chk("bs0_echo_valid", echo_valid, 0);
      chk("bs0_key_ready", key_ready, 1);
      @(posedge clk); #1;
    end
    send_key(8'h0D);
    wait_done();
    chk("empty_len", line_len, 0);
    ack();

    // "abc" BS CR
    elog.delete();
    send_str("abc"); send_key(8'h08); send_key(8'h0D);
    wait_done();
    chk("s2_bs0", elog[3], 8'h08);
    chk("s2_bs1", elog[4], 8'h20);
    chk("s2_bs2", elog[5], 8'h08);
    chk("s2_len", line_len, 2);
    peek(3'd0, 8'h61, "s2_idx0");
    peek(3'd1, 8'h62, "s2_idx1");
    ack();

    // DEPTH+1 characters: last one dropped with BEL
    elog.delete();
    for (int i = 0; i <= DEPTH; i++) send_key(8'h78);
    cyc(2);
    chk("ovf_bel", elog[elog.size()-1], 8'h07);
    chk("ovf_flag", overflow, 1);
    send_key(8'h0D);
    wait_done();
    chk("ovf_len", line_len, DEPTH);
    ack();
    @(negedge clk); chk("ovf_cleared", overflow, 0);
    @(posedge clk); #1;

    // printer stalls for 5 cycles
    rdy_fix = 1'b0;
    send_key(8'h71);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", echo_valid, 1);
      chk("stall_data", echo_data, 8'h71);
      chk("stall_key_ready", key_ready, 0);
      @(posedge clk); #1;
    end
    rdy_fix = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("stall_drained", echo_valid, 0);
    chk("stall_key_ready_back", key_ready, 1);
    @(posedge clk); #1;

    // reset in the middle of a backspace echo, on the 0x20
    send_key(8'h7A);
    cyc(1);
    rdy_fix = 1'b0;
    send_key(8'h08);
    rdy_fix = 1'b1;
    cyc(1);
    rdy_fix = 1'b0;
    @(negedge clk); chk("mid_bs_sp", echo_data, 8'h20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_fix = 1'b1;
    send_key(8'h6B);
    @(negedge clk); chk("post_rst_echo", echo_data, 8'h6B);
    @(posedge clk); #1;

    // randomized traffic against the model
    rdy_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 70) k = r[0] ? 8'h08 : 8'h7F;
      else if (r < 77) k = 8'h0D;
      else if (r < 85) k = 8'($urandom);
      else if (r < 90) k = 8'($urandom_range(0, 8'h1F));
      else if (r < 95) begin ack(); continue; end
      else if (r < 97) begin
        key_valid = 1'b0; rst_n = 1'b0; cyc(2); rst_n = 1'b1; continue;
      end else begin cyc(3); continue; end
      send_key(k);
      if (k == 8'h0D) begin
        wait_done();
        repeat (4) begin line_rd_idx = 3'($urandom); cyc(1); end
        ack();
      end
      cyc($urandom_range(0, 2));
    end
    rdy_rand = 1'b0;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
